chromakey_filter: RTL and testbench
===================================

// Module: chromakey_filter
// PURPOSE
//  Parametrised, pipelined chroma-key mask generator for the camera->VGA path.
//  Classifies each RGB pixel as background for a runtime-selectable key colour (G/B/R).
//  Thresholds are programmable and frame-synchronous; a causal horizontal majority filter suppresses speckle.
//  Also reports a per-frame foreground pixel count to the motion-recognition game logic.
// PARAMETERS
//  R_W    5   red bits in rgbData (MSB field)
//  G_W    6   green bits (middle field)
//  B_W    5   blue bits (LSB field)
//  CW     8   internal compare width; every channel is expanded to CW bits
//  FILT   3   majority window in pixels; legal values are 1, 3, 5
//  CNT_W  19  foreground counter width (640x480 fits)
// PORTS
//  clk         in   1              pixel clock
//  reset       in   1              synchronous, active-high
//  rgbData     in   R_W+G_W+B_W    packed {R,G,B}
//  DE          in   1              pixel valid / active video
//  frame_start in   1              1-cycle pulse before first pixel of frame
//  key_sel     in   2              00 green, 01 blue, 10 red, 11 keying disabled
//  cfg_we      in   1              threshold write strobe
//  cfg_addr    in   2              0 KMIN, 1 D1, 2 D2, 3 SATMIN
//  cfg_wdata   in   CW             threshold value
//  bg_pixel    out  1              filtered background flag, qualified by out_valid
//  out_valid   out  1              DE delayed by LAT=3
//  fg_count    out  CNT_W          foreground count of the previous frame
//  fg_count_vld out 1              1-cycle pulse when fg_count updates
// BEHAVIOUR
//  - Reset values:
//    - all outputs are 0; pipeline and window are cleared.
//    - active and shadow thresholds load defaults KMIN=48, D1=12, D2=8, SATMIN=24.
//  - Channel expansion:
//    - each channel is left-justified to CW bits; low bits are filled by cyclic MSB
//      replication (5b r -> {r,r[4:2]}; 6b g -> {g,g[5:4]}).
//    - DE=0 forces the expanded channels to 0.
//  - Classification (key=K, others=O1,O2; for red, O1=G, O2=B):
//    - raw = K>=O1+D1 && K>=O2+D2 && K>=KMIN && (max-min)>=SATMIN.
//    - sums are evaluated in CW+1 bits, so no wrap occurs.
//    - key_sel=11 forces raw=0.
//  - Pipeline (fixed latency LAT=3, no stalls):
//    - S1 registers the expanded channels, DE and key_sel.
//    - S2 registers raw.
//    - S3 registers the filter output.
//  - Filter:
//    - the window holds raw of the current pixel plus the previous FILT-1 pixels of the
//      same line; bg_pixel = count >= (FILT+1)/2.
//    - window slots are cleared (treated as foreground) while DE=0, so no leakage across
//      lines; the first pixels of a line can therefore only be bg if the majority is met.
//    - FILT=1 is a pass-through of raw.
//  - Config:
//    - cfg_we writes the shadow register at cfg_addr.
//    - shadow -> active copy happens only on the frame_start cycle.
//    - cfg_we coincident with frame_start: the new value is written to shadow and becomes
//      active at the next frame_start.
//    - key_sel is sampled per pixel and is not shadowed.
//  - Counter:
//    - counts out_valid && !bg_pixel; saturates at 2^CNT_W-1.
//    - frame_start: fg_count <= counter, fg_count_vld=1 next cycle, counter <= 0.
//    - an out_valid pixel on the frame_start cycle counts toward the new frame
//      (counter <= its contribution).
//  - frame_start while DE=1 is legal: the counter handoff happens as above; the pipeline
//    is unaffected.
//  - Reset mid-frame: everything returns to reset values; the first fg_count_vld after
//    reset follows the first frame_start.
// STRUCTURE
//  - chromakey_pkg:
//    - key_sel_e enum.
//    - cfg address localparams.
//    - default thresholds KMIN_DEF/D1_DEF/D2_DEF/SATMIN_DEF.
//    - function expand_ch(width, value).
//  - Sub-module chromakey_cmp (combinational):
//    - expanded R/G/B, key_sel and thresholds in, raw out.
//    - instantiated in S2.
//  - Top-level owns the shadow/active regs, pipeline, majority window and counter.
// TESTING
//  1. Reset defaults, FILT=1, green key:
//     - rgb565 {0,63,0} with DE=1 -> bg_pixel=1, out_valid 3 cycles later.
//     - {31,63,31} (white) -> bg_pixel=0 (SAT fail).
//  2. key_sel=01:
//     - {0,0,31} -> bg=1; {0,63,0} -> bg=0.
//     - key_sel=11 -> bg=0 for all inputs.
//  3. Threshold update:
//     - write KMIN=255 mid-frame -> green pixels stay bg=1 until frame_start, then bg=0.
//     - write on the frame_start cycle -> takes effect one frame later.
//  4. FILT=3:
//     - raw pattern bg,bg,fg,bg,bg -> output 0,1,1,1,1 (first pixel fails majority,
//       lone fg is removed).
//     - DE gap between lines -> first pixel of the new line is 0.
//  5. Counter:
//     - 640x480 frame with 1000 fg pixels -> fg_count=1000 with a fg_count_vld pulse
//       after the next frame_start.
//     - CNT_W=4 with 20 fg pixels -> 15.
//  6. Reset asserted mid-line:
//     - out_valid=0, bg_pixel=0, fg_count=0 next cycle.
//     - thresholds return to defaults.

Source files
------------

// File: rtl/chromakey_pkg.sv
// Shared types, configuration addresses, default thresholds and the channel
// expansion helper for the chroma-key mask generator.
package chromakey_pkg;

  typedef enum logic [1:0] {
    KEY_GREEN = 2'b00,
    KEY_BLUE  = 2'b01,
    KEY_RED   = 2'b10,
    KEY_OFF   = 2'b11
  } key_sel_e;

  localparam logic [1:0] CFG_KMIN   = 2'd0;
  localparam logic [1:0] CFG_D1     = 2'd1;
  localparam logic [1:0] CFG_D2     = 2'd2;
  localparam logic [1:0] CFG_SATMIN = 2'd3;

  localparam int KMIN_DEF   = 48;
  localparam int D1_DEF     = 12;
  localparam int D2_DEF     = 8;
  localparam int SATMIN_DEF = 24;

  // Widest channel expansion the helper can produce
  localparam int EXP_MAX = 16;

  // Left-justify a width-bit value into EXP_MAX bits, filling the low bits by
  // cyclic replication from the MSB down (5b r -> {r, r[4:2], ...}).
  function automatic logic [EXP_MAX-1:0] expand_ch(input int width,
                                                   input logic [EXP_MAX-1:0] value);
    logic [EXP_MAX-1:0] res;
    res = {EXP_MAX{1'b0}};
    for (int i = 0; i < EXP_MAX; i++) begin
      res[EXP_MAX-1-i] = value[width-1-(i % width)];
    end
    return res;
  endfunction

endpackage

// File: rtl/chromakey_filter_cmp.sv
// Combinational background classifier for one expanded RGB pixel.
module chromakey_cmp
  import chromakey_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] r_i,
  input  logic [CW-1:0] g_i,
  input  logic [CW-1:0] b_i,
  input  key_sel_e      key_sel_i,
  input  logic [CW-1:0] kmin_i,
  input  logic [CW-1:0] d1_i,
  input  logic [CW-1:0] d2_i,
  input  logic [CW-1:0] satmin_i,
  output logic          raw_o
);

  logic [CW-1:0] k_s, o1_s, o2_s, max_s, min_s;
  logic [CW:0]   o1_sum_s, o2_sum_s;
  logic          en_s;

  // Route the key channel and the two other channels
  always_comb begin
    k_s  = g_i;
    o1_s = r_i;
    o2_s = b_i;
    en_s = 1'b1;
    case (key_sel_i)
      KEY_GREEN: begin k_s = g_i; o1_s = r_i; o2_s = b_i; end
      KEY_BLUE:  begin k_s = b_i; o1_s = r_i; o2_s = g_i; end
      KEY_RED:   begin k_s = r_i; o1_s = g_i; o2_s = b_i; end
      default:   begin en_s = 1'b0; end
    endcase
  end

  // Saturation span: largest minus smallest channel
  always_comb begin
    max_s = r_i;
    min_s = r_i;
    if (g_i > max_s) max_s = g_i; else max_s = max_s;
    if (b_i > max_s) max_s = b_i; else max_s = max_s;
    if (g_i < min_s) min_s = g_i; else min_s = min_s;
    if (b_i < min_s) min_s = b_i; else min_s = min_s;
  end

  // Margins are summed one bit wider so a large offset can never wrap
  always_comb begin
    o1_sum_s = {1'b0, o1_s} + {1'b0, d1_i};
    o2_sum_s = {1'b0, o2_s} + {1'b0, d2_i};
    raw_o    = en_s
             && ({1'b0, k_s} >= o1_sum_s)
             && ({1'b0, k_s} >= o2_sum_s)
             && (k_s >= kmin_i)
             && ((max_s - min_s) >= satmin_i);
  end

endmodule

// File: rtl/chromakey_filter.sv
// Chroma-key mask generator: three-stage pipeline (expand, classify, filter),
// frame-synchronous thresholds and a per-frame foreground pixel counter.
module chromakey_filter
  import chromakey_pkg::*;
#(
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5,
  parameter int CW    = 8,
  parameter int FILT  = 3,
  parameter int CNT_W = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [R_W+G_W+B_W-1:0]   rgbData,
  input  logic                     DE,
  input  logic                     frame_start,
  input  logic [1:0]               key_sel,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_addr,
  input  logic [CW-1:0]            cfg_wdata,
  output logic                     bg_pixel,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         fg_count,
  output logic                     fg_count_vld
);

  localparam int PW = R_W + G_W + B_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0][CW-1:0] THR_DEF =
    {CW'(SATMIN_DEF), CW'(D2_DEF), CW'(D1_DEF), CW'(KMIN_DEF)};

  logic [3:0][CW-1:0] shadow_d, shadow_q, active_d, active_q;
  logic [CW-1:0]      r1_d, r1_q, g1_d, g1_q, b1_d, b1_q;
  logic               de1_d, de1_q;
  key_sel_e           ks1_d, ks1_q;
  logic               raw_s, raw2_d, raw2_q, de2_d, de2_q;
  logic               maj_s, bg3_d, bg3_q, ov3_d, ov3_q;
  logic               contrib_s;
  logic [CNT_W-1:0]   cnt_d, cnt_q, fg_count_d, fg_count_q;
  logic               fg_vld_d, fg_vld_q;

  // Writes land in shadow; active picks up the old shadow only on frame_start
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_we) shadow_d[cfg_addr] = cfg_wdata; else shadow_d = shadow_q;
    if (frame_start) active_d = shadow_q; else active_d = active_q;
  end

  // Threshold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= THR_DEF;
      active_q <= THR_DEF;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // S1 input: expand each channel to CW bits, blanked outside active video
  always_comb begin
    ks1_d = key_sel_e'(key_sel);
    de1_d = DE;
    if (DE) begin
      r1_d = CW'(expand_ch(R_W, {{(EXP_MAX-R_W){1'b0}}, rgbData[PW-1 -: R_W]}) >> (EXP_MAX - CW));
      g1_d = CW'(expand_ch(G_W, {{(EXP_MAX-G_W){1'b0}}, rgbData[B_W +: G_W]}) >> (EXP_MAX - CW));
      b1_d = CW'(expand_ch(B_W, {{(EXP_MAX-B_W){1'b0}}, rgbData[0 +: B_W]}) >> (EXP_MAX - CW));
    end else begin
      r1_d = {CW{1'b0}};
      g1_d = {CW{1'b0}};
      b1_d = {CW{1'b0}};
    end
  end

  chromakey_cmp #(.CW(CW)) u_cmp (
    .r_i       (r1_q),
    .g_i       (g1_q),
    .b_i       (b1_q),
    .key_sel_i (ks1_q),
    .kmin_i    (active_q[CFG_KMIN]),
    .d1_i      (active_q[CFG_D1]),
    .d2_i      (active_q[CFG_D2]),
    .satmin_i  (active_q[CFG_SATMIN]),
    .raw_o     (raw_s)
  );

  // S2 classify and S3 filter inputs; blank pixels never count as background
  always_comb begin
    raw2_d = de1_q & raw_s;
    de2_d  = de1_q;
    bg3_d  = maj_s;
    ov3_d  = de2_q;
  end

  // Pipeline registers for all three stages
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q   <= {CW{1'b0}};
      g1_q   <= {CW{1'b0}};
      b1_q   <= {CW{1'b0}};
      de1_q  <= 1'b0;
      ks1_q  <= KEY_GREEN;
      raw2_q <= 1'b0;
      de2_q  <= 1'b0;
      bg3_q  <= 1'b0;
      ov3_q  <= 1'b0;
    end else begin
      r1_q   <= r1_d;
      g1_q   <= g1_d;
      b1_q   <= b1_d;
      de1_q  <= de1_d;
      ks1_q  <= ks1_d;
      raw2_q <= raw2_d;
      de2_q  <= de2_d;
      bg3_q  <= bg3_d;
      ov3_q  <= ov3_d;
    end
  end

  generate
    if (FILT > 1) begin : g_win
      localparam int HW = FILT - 1;
      localparam int SW = $clog2(FILT + 1);
      localparam logic [SW-1:0] MAJ = SW'((FILT + 1) / 2);
      logic [HW-1:0] hist_d, hist_q;
      logic [SW-1:0] ones_s;

      // Line history of earlier raws; blanking empties it so lines never mix
      always_comb begin
        if (de2_q) hist_d = HW'({hist_q, raw2_q}); else hist_d = {HW{1'b0}};
      end

      // History register
      always_ff @(posedge clk) begin
        if (reset) hist_q <= {HW{1'b0}};
        else       hist_q <= hist_d;
      end

      // Majority vote over the current raw and the history
      always_comb begin
        ones_s = SW'(raw2_q);
        for (int i = 0; i < HW; i++) begin
          ones_s = ones_s + SW'(hist_q[i]);
        end
        if (de2_q) maj_s = (ones_s >= MAJ); else maj_s = 1'b0;
      end
    end else begin : g_pass
      // Single-pixel window: raw passes straight through
      always_comb begin
        maj_s = raw2_q;
      end
    end
  endgenerate

  // Foreground counter with saturation and frame_start handoff
  always_comb begin
    contrib_s  = ov3_q & ~bg3_q;
    cnt_d      = cnt_q;
    fg_count_d = fg_count_q;
    fg_vld_d   = 1'b0;
    if (frame_start) begin
      cnt_d      = CNT_W'(contrib_s);
      fg_count_d = cnt_q;
      fg_vld_d   = 1'b1;
    end else if (contrib_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and report registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= {CNT_W{1'b0}};
      fg_count_q <= {CNT_W{1'b0}};
      fg_vld_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      fg_count_q <= fg_count_d;
      fg_vld_q   <= fg_vld_d;
    end
  end

  assign bg_pixel     = bg3_q;
  assign out_valid    = ov3_q;
  assign fg_count     = fg_count_q;
  assign fg_count_vld = fg_vld_q;

endmodule

// File: tb/tb_chromakey_filter.sv
// Bench for chromakey_filter: two instances (FILT=1/CNT_W=19 and FILT=3/CNT_W=4)
// share one stimulus stream and are compared every cycle against a pixel-level model.
module tb_chromakey_filter;

  localparam logic [15:0] GREEN  = 16'h07E0;  // {0,63,0}
  localparam logic [15:0] GREEN2 = 16'h0780;  // {0,60,0}, expands to 243
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam int MAX1 = (1 << 19) - 1;
  localparam int MAX3 = 15;

  logic        clk = 1'b0;
  logic        reset, de, frame_start, cfg_we;
  logic [15:0] rgb_data;
  logic [1:0]  key_sel, cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        bg1, ov1, fgv1, bg3, ov3, fgv3;
  logic [18:0] fgc1;
  logic [3:0]  fgc3;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  int thr_sh[4];
  int thr_act[4];
  int line_q[$];
  bit v_p[3];
  bit b1_p[3];
  bit b3_p[3];
  int cnt1, cnt3, fgm1, fgm3;
  bit vldm;

  always #5 clk = ~clk;

  chromakey_filter #(.FILT(1), .CNT_W(19)) dut1 (
    .clk(clk), .reset(reset), .rgbData(rgb_data), .DE(de), .frame_start(frame_start),
    .key_sel(key_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .bg_pixel(bg1), .out_valid(ov1), .fg_count(fgc1), .fg_count_vld(fgv1)
  );

  chromakey_filter #(.FILT(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .rgbData(rgb_data), .DE(de), .frame_start(frame_start),
    .key_sel(key_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .bg_pixel(bg3), .out_valid(ov3), .fg_count(fgc3), .fg_count_vld(fgv3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Background decision from the keying rules, using 8-bit expanded channels
  function automatic bit model_raw(input logic [15:0] px, input bit de_i, input logic [1:0] ks);
    int r, g, b, k, o1, o2, mx, mn;
    if (!de_i || ks == 2'b11) return 1'b0;
    r = int'(px[15:11]); r = r * 8 + r / 4;
    g = int'(px[10:5]);  g = g * 4 + g / 16;
    b = int'(px[4:0]);   b = b * 8 + b / 4;
    case (ks)
      2'b00:   begin k = g; o1 = r; o2 = b; end
      2'b01:   begin k = b; o1 = r; o2 = g; end
      default: begin k = r; o1 = g; o2 = b; end
    endcase
    mx = (r > g) ? r : g; mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g; mn = (b < mn) ? b : mn;
    return (k >= o1 + thr_act[1]) && (k >= o2 + thr_act[2]) &&
           (k >= thr_act[0]) && ((mx - mn) >= thr_act[3]);
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic [15:0] px, input bit de_i, input bit fs_i,
                      input logic [1:0] ks, input bit we_i, input logic [1:0] a_i,
                      input logic [7:0] wd_i, input bit rst_i);
    bit raw, bg1e, bg3e, c1, c3;
    int s;
    @(negedge clk);
    reset = rst_i; rgb_data = px; de = de_i; frame_start = fs_i; key_sel = ks;
    cfg_we = we_i; cfg_addr = a_i; cfg_wdata = wd_i;
    if (rst_i) begin
      thr_sh  = '{48, 12, 8, 24};
      thr_act = '{48, 12, 8, 24};
      line_q.delete();
      for (int i = 0; i < 3; i++) begin v_p[i] = 0; b1_p[i] = 0; b3_p[i] = 0; end
      cnt1 = 0; cnt3 = 0; fgm1 = 0; fgm3 = 0; vldm = 0;
    end else begin
      c1 = v_p[2] && !b1_p[2];
      c3 = v_p[2] && !b3_p[2];
      if (fs_i) begin
        fgm1 = cnt1; fgm3 = cnt3; cnt1 = int'(c1); cnt3 = int'(c3); vldm = 1;
        thr_act = thr_sh;
      end else begin
        vldm = 0;
        if (c1 && cnt1 < MAX1) cnt1++;
        if (c3 && cnt3 < MAX3) cnt3++;
      end
      if (we_i) thr_sh[a_i] = int'(wd_i);
      raw  = model_raw(px, de_i, ks);
      bg1e = raw;
      if (de_i) begin
        s = int'(raw);
        foreach (line_q[i]) s += line_q[i];
        bg3e = (s >= 2);
        line_q.push_back(int'(raw));
        if (line_q.size() > 2) void'(line_q.pop_front());
      end else begin
        bg3e = 0;
        line_q.delete();
      end
      v_p[2] = v_p[1];   v_p[1] = v_p[0];   v_p[0] = de_i;
      b1_p[2] = b1_p[1]; b1_p[1] = b1_p[0]; b1_p[0] = bg1e;
      b3_p[2] = b3_p[1]; b3_p[1] = b3_p[0]; b3_p[0] = bg3e;
    end
    @(posedge clk);
    #1;
    chk("ov1", ov1, v_p[2]);
    chk("ov3", ov3, v_p[2]);
    if (v_p[2]) begin
      chk("bg1", bg1, b1_p[2]);
      chk("bg3", bg3, b3_p[2]);
    end
    chk("fgc1", fgc1, fgm1);
    chk("fgc3", fgc3, fgm3);
    chk("fgv1", fgv1, vldm);
    chk("fgv3", fgv3, vldm);
  endtask

  task automatic pix(input logic [15:0] px, input logic [1:0] ks);
    step(px, 1'b1, 1'b0, ks, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic fs_idle();
    step(16'h0000, 1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  logic [15:0] pat_px[5];
  int          pat_bg[5];
  logic [15:0] line_px[8];
  logic [15:0] rpx;
  logic [1:0]  rks, ra;
  logic [7:0]  rwd;
  bit          rde, rfs, rwe, rrst;

  initial begin
    reset = 1'b1; de = 1'b0; frame_start = 1'b0; key_sel = 2'b00;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0; rgb_data = 16'h0000;

    // Reset state
    step(16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 8'd0, 1'b1);
    step(16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("rst_ov", ov1, 1'b0);
    chk("rst_fgc", fgc1, 32'd0);

    // Default thresholds, green key, latency
    pix(GREEN, 2'b00);
    idle(1);
    chk("t1_lat_early", ov1, 1'b0);
    idle(1);
    chk("t1_lat_ov", ov1, 1'b1);
    chk("t1_green_bg", bg1, 1'b1);
    pix(WHITE, 2'b00); idle(2);
    chk("t1_white_fg", bg1, 1'b0);

    // Blue key and keying disabled
    pix(BLUE, 2'b01); idle(2);
    chk("t2_blue_bg", bg1, 1'b1);
    pix(GREEN, 2'b01); idle(2);
    chk("t2_green_fg", bg1, 1'b0);
    pix(GREEN, 2'b11); idle(2);
    chk("t2_off_green", bg1, 1'b0);
    pix(BLUE, 2'b11); idle(2);
    chk("t2_off_blue", bg1, 1'b0);

    // Threshold write mid-frame, then on a frame_start cycle
    fs_idle();
    pix(GREEN2, 2'b00);
    step(GREEN2, 1'b1, 1'b0, 2'b00, 1'b1, 2'd0, 8'd255, 1'b0);
    pix(GREEN2, 2'b00); idle(2);
    chk("t3_before_fs", bg1, 1'b1);
    step(GREEN2, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 8'd0, 1'b0);
    idle(2);
    chk("t3_after_fs", bg1, 1'b0);
    step(GREEN2, 1'b1, 1'b1, 2'b00, 1'b1, 2'd0, 8'd48, 1'b0);
    idle(2);
    chk("t3_fs_write_pending", bg1, 1'b0);
    fs_idle();
    pix(GREEN2, 2'b00); idle(2);
    chk("t3_fs_write_active", bg1, 1'b1);

    // Majority of three: bg,bg,fg,bg,bg -> 0,1,1,1,1
    pat_px = '{GREEN, GREEN, WHITE, GREEN, GREEN};
    pat_bg = '{0, 1, 1, 1, 1};
    for (int k = 0; k < 7; k++) begin
      if (k < 5) pix(pat_px[k], 2'b00); else idle(1);
      if (k >= 2) chk("t4_majority", bg3, pat_bg[k-2][0]);
    end
    // No leakage across a DE gap
    line_px = '{GREEN, GREEN, GREEN, 16'h0000, GREEN, GREEN, 16'h0000, 16'h0000};
    for (int k = 0; k < 8; k++) begin
      step(line_px[k], (k != 3 && k < 6), 1'b0, 2'b00, 1'b0, 2'd0, 8'd0, 1'b0);
      if (k == 6) chk("t4_line_first", bg3, 1'b0);
      if (k == 7) chk("t4_line_second", bg3, 1'b1);
    end

    // Frame with 1000 fg pixels; narrow counter saturates
    idle(3);
    fs_idle();
    for (int k = 0; k < 1200; k++) pix((k < 1000) ? WHITE : GREEN, 2'b00);
    idle(3);
    fs_idle();
    chk("t5_fgc_1000", fgc1, 32'd1000);
    chk("t5_fgv", fgv1, 1'b1);
    chk("t5_fgc_sat", fgc3, 32'd15);
    idle(1);
    chk("t5_fgv_pulse", fgv1, 1'b0);

    // Reset mid-line restores defaults
    step(16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0, 8'd255, 1'b0);
    fs_idle();
    pix(GREEN2, 2'b00); pix(GREEN2, 2'b00); pix(GREEN2, 2'b00);
    step(GREEN2, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("t6_ov", ov1, 1'b0);
    chk("t6_bg", bg1, 1'b0);
    chk("t6_fgc", fgc1, 32'd0);
    pix(GREEN2, 2'b00); idle(2);
    chk("t6_defaults", bg1, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rpx = {5'($urandom_range(0, 6)), 6'($urandom_range(40, 63)), 5'($urandom_range(0, 6))};
        1: rpx = {5'($urandom_range(0, 6)), 6'($urandom_range(0, 12)), 5'($urandom_range(20, 31))};
        2: rpx = {5'($urandom_range(20, 31)), 6'($urandom_range(0, 12)), 5'($urandom_range(0, 6))};
        default: rpx = 16'($urandom);
      endcase
      rde  = ($urandom_range(0, 9) != 0);
      rfs  = ($urandom_range(0, 199) == 0);
      rks  = 2'($urandom_range(0, 3));
      rwe  = ($urandom_range(0, 19) == 0);
      ra   = 2'($urandom_range(0, 3));
      rwd  = 8'($urandom_range(0, 80));
      rrst = ($urandom_range(0, 1499) == 0);
      step(rpx, rde, rfs, rks, rwe, ra, rwd, rrst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
